// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the pipeline sequencing logic.
//   ctrl_state_e : sequencing FSM states (RUN / MEM_WAIT / FLUSH)
//   seq_ctrl_t   : the enable/flush/redirect bundle driven to the pipeline
//   CTRL_ZERO    : control word loaded into a pipeline register as a bubble
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  // Width of the per-instruction control word carried by IF/ID and ID/EX.
  localparam int CTRL_WORD_W = 12;
  // A bubble is an instruction with every control bit cleared.
  localparam logic [CTRL_WORD_W-1:0] CTRL_ZERO = '0;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic pc_redirect;
  } seq_ctrl_t;

  // Everything frozen (data-memory stall).
  localparam seq_ctrl_t SEQ_HOLD = '{default: 1'b0};

  // Normal flow: every register loads, nothing is squashed.
  localparam seq_ctrl_t SEQ_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                     exmem_en: 1'b1, ifid_flush: 1'b0,
                                     idex_flush: 1'b0, pc_redirect: 1'b0};

  // Flow with IF/ID and ID/EX squashed (reset and post-redirect cycles).
  localparam seq_ctrl_t SEQ_SQUASH = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                       exmem_en: 1'b1, ifid_flush: 1'b1,
                                       idex_flush: 1'b1, pc_redirect: 1'b0};

  // Redirect: squash the wrong-path instructions and load the corrected PC.
  localparam seq_ctrl_t SEQ_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                         exmem_en: 1'b1, ifid_flush: 1'b1,
                                         idex_flush: 1'b1, pc_redirect: 1'b1};

  // Load-use: hold PC and IF/ID, insert one bubble into ID/EX, let EX advance.
  localparam seq_ctrl_t SEQ_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1,
                                         exmem_en: 1'b1, ifid_flush: 1'b0,
                                         idex_flush: 1'b1, pc_redirect: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational hazard classification for the instruction
// pair sitting in ID and EX.
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID-stage source operands
//   ex_rd, ex_MemRd, ex_RegWr              : EX-stage destination / class
//   ex_Branch, ex_Jump, ex_PCspecial       : EX control-flow class
//   ex_predicted_bit, ex_taken             : prediction vs. real outcome
//   load_use   : ID needs a value an EX load has not produced yet
//   mispredict : fetch went down the wrong path, EX must redirect
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRd,
  input  logic       ex_RegWr,
  input  logic       ex_Branch,
  input  logic       ex_Jump,
  input  logic       ex_PCspecial,
  input  logic       ex_predicted_bit,
  input  logic       ex_taken,
  output logic       load_use,
  output logic       mispredict
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hard-wired zero, so a load targeting it creates no dependency.
  assign load_use = ex_MemRd && ex_RegWr && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // jalr targets are never predicted, so it always redirects.
  assign mispredict = ex_PCspecial ||
                      ((ex_Branch || ex_Jump) && (ex_taken != ex_predicted_bit));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// Each cycle decides whether PC, IF/ID, ID/EX and EX/MEM load, hold or take a
// bubble, and keeps saturating stall / flush statistics.
//   clk, rst (sync, active-high)
//   id_*, ex_*            : hazard inputs from ID and EX
//   mem_MemRd, mem_MemWr  : MEM-stage access in flight
//   dmem_ready            : completion strobe; an access in flight without it
//                           this cycle freezes the whole pipeline
//   pc_en .. exmem_en     : register load enables
//   ifid_flush, idex_flush: load CTRL_ZERO (bubble)
//   pc_redirect           : select the corrected PC computed in EX
//   mem_err               : sticky data-memory timeout
//   ctrl_state            : current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2)
//   stall_cnt, flush_cnt  : saturating event counters
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRd,
  input  logic             ex_RegWr,
  input  logic             ex_Branch,
  input  logic             ex_Jump,
  input  logic             ex_PCspecial,
  input  logic             ex_predicted_bit,
  input  logic             ex_taken,
  input  logic             mem_MemRd,
  input  logic             mem_MemWr,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pc_redirect,
  output logic             mem_err,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO_LIMIT  = 16'(MEM_TIMEOUT);

  logic load_use;
  logic mispredict;
  logic mem_busy;

  hazard_detect u_detect (
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .ex_rd            (ex_rd),
    .ex_MemRd         (ex_MemRd),
    .ex_RegWr         (ex_RegWr),
    .ex_Branch        (ex_Branch),
    .ex_Jump          (ex_Jump),
    .ex_PCspecial     (ex_PCspecial),
    .ex_predicted_bit (ex_predicted_bit),
    .ex_taken         (ex_taken),
    .load_use         (load_use),
    .mispredict       (mispredict)
  );

  assign mem_busy = (mem_MemRd || mem_MemWr) && !dmem_ready;

  ctrl_state_e      state_q, state_d;
  logic [2:0]       fctr_q, fctr_d;   // flush cycles still owed
  logic [15:0]      tmo_q, tmo_d;     // consecutive stalled memory cycles
  logic             err_q, set_err;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_ev, flush_ev;
  seq_ctrl_t        ctl;

  // Cycle classification. A stalled access beats everything. Owed flush
  // cycles come next: they are paid in FLUSH and, if a memory stall cut a
  // flush sequence short, in the MEM_WAIT cycle where the access completes.
  // Otherwise the RUN rules apply (also for the unused encoding).
  logic hold_cyc;
  logic flush_cyc;

  assign hold_cyc  = mem_busy;
  assign flush_cyc = !mem_busy &&
                     ((state_q == FLUSH) || ((state_q == MEM_WAIT) && (fctr_q != 3'd0)));

  always_comb begin
    ctl      = SEQ_FLOW;
    state_d  = state_q;
    fctr_d   = fctr_q;
    tmo_d    = tmo_q;
    set_err  = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;

    if (rst) begin
      ctl     = SEQ_SQUASH;
      state_d = RUN;
      fctr_d  = 3'd0;
      tmo_d   = 16'd0;
    end else if (hold_cyc) begin
      // The flush counter is left alone so an interrupted flush resumes.
      ctl      = SEQ_HOLD;
      stall_ev = 1'b1;
      state_d  = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        tmo_d = 16'd1;
      end else if (tmo_q < TMO_LIMIT) begin
        tmo_d = tmo_q + 16'd1;
      end
      set_err = (tmo_d >= TMO_LIMIT);
    end else if (flush_cyc) begin
      // EX holds a bubble here, so any mispredict/load_use is ignored.
      ctl     = SEQ_SQUASH;
      fctr_d  = (fctr_q == 3'd0) ? 3'd0 : fctr_q - 3'd1;
      state_d = (fctr_q <= 3'd1) ? RUN : FLUSH;
    end else begin
      state_d = RUN;
      if (mispredict) begin
        ctl      = SEQ_REDIRECT;
        flush_ev = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fctr_d  = FLUSH_INIT;
        end
      end else if (load_use) begin
        ctl      = SEQ_LOAD_USE;
        stall_ev = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fctr_q  <= 3'd0;
      tmo_q   <= 16'd0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fctr_q  <= fctr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_q || set_err;
      if (stall_ev && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_ev && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign pc_en       = ctl.pc_en;
  assign ifid_en     = ctl.ifid_en;
  assign idex_en     = ctl.idex_en;
  assign exmem_en    = ctl.exmem_en;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign pc_redirect = ctl.pc_redirect;
  assign mem_err     = err_q;
  assign ctrl_state  = state_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

endmodule
